// File: rtl/bitmap_assembler_if.sv
// bitmap_assembler_if -- handshake bundle for bitmap_assembler.
//
// Parameter N is the bitmap width, a power of two from 2 to 32.
// The index width IW is clog2(N). The count width CW is IW+1, so the
// count can reach N.
//
// Signals:
//   in_valid   : an index and its last flag are presented
//   in_ready   : the assembler accepts an index this cycle
//   in_index   : bit position to set in the current frame (IW bits)
//   in_last    : this index closes the frame
//   out_valid  : a completed frame is presented
//   out_ready  : downstream accepts the frame
//   out_bitmap : OR of one-hot(in_index) over the frame (N bits)
//   out_count  : number of distinct bits set in out_bitmap (CW bits)
//   out_dup    : at least one index in the frame was already set
//
// Modports:
//   slave  : the assembler's view
//   master : the producer/consumer view
interface bitmap_assembler_if #(
    parameter int N = 32
);
    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_index;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_bitmap;
    logic [CW-1:0] out_count;
    logic          out_dup;

    modport slave (
        input  in_valid, in_index, in_last, out_ready,
        output in_ready, out_valid, out_bitmap, out_count, out_dup
    );

    modport master (
        output in_valid, in_index, in_last, out_ready,
        input  in_ready, out_valid, out_bitmap, out_count, out_dup
    );
endinterface

// File: rtl/bitmap_assembler.sv
// bitmap_assembler -- collects a frame of bit indices into an N-bit bitmap.
//
// Each accepted index sets one bit of the accumulator. The frame's
// distinct-bit count and a sticky duplicate flag are kept alongside the
// bitmap. The index that carries in_last closes the frame. The block then
// holds the result on the output side until downstream takes it. The
// accumulator clears on that same edge.
//
// Ports:
//   clk : clock; all state updates on its rising edge
//   rst : synchronous, active-high reset
//   bus : bitmap_assembler_if.slave (in_* index stream, out_* frame result)
module bitmap_assembler #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    bitmap_assembler_if.slave    bus
);
    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  acc_bitmap_q, acc_bitmap_d;
    logic [CW-1:0] acc_count_q, acc_count_d;
    logic          acc_dup_q, acc_dup_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            acc_bitmap_q <= '0;
            acc_count_q  <= '0;
            acc_dup_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_bitmap_q <= acc_bitmap_d;
            acc_count_q  <= acc_count_d;
            acc_dup_q    <= acc_dup_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_bitmap_d = acc_bitmap_q;
        acc_count_d  = acc_count_q;
        acc_dup_d    = acc_dup_q;
        case (state_q)
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_bitmap_d[bus.in_index] = 1'b1;
                    // The pre-edge bitmap decides whether this index is new.
                    // Count only grows on a new bit, so it cannot pass N.
                    if (acc_bitmap_q[bus.in_index]) begin
                        acc_dup_d = 1'b1;
                    end else begin
                        acc_count_d = acc_count_q + CW'(1);
                    end
                    if (bus.in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Clear on the handshake edge so the next frame starts empty.
                if (bus.out_ready) begin
                    state_d      = ACCUM;
                    acc_bitmap_d = '0;
                    acc_count_d  = '0;
                    acc_dup_d    = 1'b0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Both handshake flags are forced low during reset.
    // in_ready does not depend on out_ready.
    assign bus.in_ready   = (state_q == ACCUM) && !rst;
    assign bus.out_valid  = (state_q == HOLD) && !rst;
    assign bus.out_bitmap = acc_bitmap_q;
    assign bus.out_count  = acc_count_q;
    assign bus.out_dup    = acc_dup_q;
endmodule

// File: tb/tb_bitmap_assembler.sv
// tb_bitmap_assembler -- directed and throttled-random stimulus for
// bitmap_assembler at N=32 and N=8. A frame-level reference model tracks
// each instance. The model keeps the pending flag, the OR of accepted
// indices, and the number of accepts. A negedge compare process checks
// both instances every cycle.
module tb_bitmap_assembler;
    logic clk;
    logic rst;

    bitmap_assembler_if #(.N(32)) b32();
    bitmap_assembler_if #(.N(8))  b8();

    bitmap_assembler #(.N(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    bitmap_assembler #(.N(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int last_cyc;

    // Reference model state, index 0 = N=32 instance, 1 = N=8 instance.
    bit          pend [2];
    logic [31:0] mbm  [2];
    int          macc [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic upd(input int k, input logic r, input logic v, input int unsigned idx,
                       input logic l, input logic ordy);
        if (r) begin
            pend[k] = 1'b0;
            mbm[k]  = '0;
            macc[k] = 0;
        end else if (!pend[k]) begin
            if (v) begin
                mbm[k]  = mbm[k] | (32'd1 << idx);
                macc[k] = macc[k] + 1;
                if (l) pend[k] = 1'b1;
            end
        end else if (ordy) begin
            pend[k] = 1'b0;
            mbm[k]  = '0;
            macc[k] = 0;
        end
    endtask

    task automatic cmp(input int k, input logic rdy, input logic vld, input logic [31:0] bm,
                       input logic [31:0] cnt, input logic dup);
        int ones;
        ones = $countones(mbm[k]);
        chk(k == 0 ? "in_ready32" : "in_ready8", 32'(rdy), 32'(!pend[k] && !rst));
        chk(k == 0 ? "out_valid32" : "out_valid8", 32'(vld), 32'(pend[k] && !rst));
        if (pend[k] && !rst) begin
            chk(k == 0 ? "bitmap32" : "bitmap8", bm, mbm[k]);
            chk(k == 0 ? "count32" : "count8", cnt, 32'(ones));
            chk(k == 0 ? "dup32" : "dup8", 32'(dup), 32'(macc[k] != ones));
        end
    endtask

    // Model update: inputs change 1 time unit after each rising edge, so
    // they are stable here.
    initial begin
        forever begin
            @(posedge clk);
            upd(0, rst, b32.in_valid, 32'(b32.in_index), b32.in_last, b32.out_ready);
            upd(1, rst, b8.in_valid, 32'(b8.in_index), b8.in_last, b8.out_ready);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cmp(0, b32.in_ready, b32.out_valid, b32.out_bitmap, 32'(b32.out_count), b32.out_dup);
            cmp(1, b8.in_ready, b8.out_valid, 32'(b8.out_bitmap), 32'(b8.out_count), b8.out_dup);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one index and wait (bounded) until it is accepted.
    task automatic send(input int k, input int unsigned idx, input bit last);
        logic r;
        int   cyc;
        r   = 1'b0;
        cyc = 0;
        if (k == 0) begin
            b32.in_valid = 1'b1;
            b32.in_index = 5'(idx);
            b32.in_last  = last;
        end else begin
            b8.in_valid = 1'b1;
            b8.in_index = 3'(idx);
            b8.in_last  = last;
        end
        while (!r && cyc < 20) begin
            @(negedge clk);
            r = (k == 0) ? b32.in_ready : b8.in_ready;
            step();
            cyc++;
        end
        chk("send_accept", 32'(r), 32'd1);
        last_cyc = cyc;
        b32.in_valid = 1'b0;
        b8.in_valid  = 1'b0;
    endtask

    task automatic check_frame32(input string tag, input logic [31:0] bm, input int cnt, input bit dup);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(b32.out_valid), 32'd1);
        chk({tag, "_bitmap"}, b32.out_bitmap, bm);
        chk({tag, "_count"}, 32'(b32.out_count), 32'(cnt));
        chk({tag, "_dup"}, 32'(b32.out_dup), 32'(dup));
    endtask

    initial begin
        int tot;
        rst           = 1'b1;
        b32.in_valid  = 1'b0;
        b32.in_index  = '0;
        b32.in_last   = 1'b0;
        b32.out_ready = 1'b1;
        b8.in_valid   = 1'b0;
        b8.in_index   = '0;
        b8.in_last    = 1'b0;
        b8.out_ready  = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("reset_in_ready", 32'(b32.in_ready), 32'd0);
        chk("reset_out_valid", 32'(b32.out_valid), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(b32.in_ready), 32'd1);
        step();

        // Frame {31, 0, 5}: result one cycle after the last accept.
        send(0, 31, 0);
        send(0, 0, 0);
        send(0, 5, 1);
        check_frame32("f_31_0_5", 32'h8000_0021, 3, 1'b0);
        step();
        @(negedge clk);
        chk("f_31_0_5_done", 32'(b32.out_valid), 32'd0);
        step();

        // Repeated index 7.
        send(0, 7, 0);
        send(0, 7, 0);
        send(0, 7, 1);
        check_frame32("f_777", 32'h0000_0080, 1, 1'b1);
        step();

        // Backpressure: hold frame {3} for 5 cycles while in_valid toggles.
        b32.out_ready = 1'b0;
        send(0, 3, 1);
        for (int i = 0; i < 5; i++) begin
            b32.in_valid = 1'b1;
            b32.in_index = 5'($urandom);
            b32.in_last  = 1'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(b32.out_valid), 32'd1);
            chk("hold_bitmap", b32.out_bitmap, 32'h8);
            chk("hold_in_ready", 32'(b32.in_ready), 32'd0);
            step();
        end
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        step();
        send(0, 9, 1);
        check_frame32("f_after_hold", 32'h0000_0200, 1, 1'b0);
        step();

        // 32 distinct indices back to back.
        tot = 0;
        for (int i = 0; i < 32; i++) begin
            send(0, i, i == 31);
            tot += last_cyc;
        end
        chk("b2b_cycles", 32'(tot), 32'd32);
        check_frame32("f_all", 32'hFFFF_FFFF, 32, 1'b0);
        step();

        // Reset mid-frame, with an index presented during reset.
        send(0, 1, 0);
        send(0, 2, 0);
        b32.in_valid = 1'b1;
        b32.in_index = 5'd2;
        b32.in_last  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(b32.in_ready), 32'd0);
        chk("midrst_out_valid", 32'(b32.out_valid), 32'd0);
        step();
        rst = 1'b0;
        b32.in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_after_ready", 32'(b32.in_ready), 32'd1);
        chk("midrst_after_valid", 32'(b32.out_valid), 32'd0);
        step();
        send(0, 4, 1);
        check_frame32("f_after_rst", 32'h0000_0010, 1, 1'b0);
        step();

        // Reset during HOLD discards the pending frame.
        b32.out_ready = 1'b0;
        send(0, 6, 1);
        check_frame32("f_pending", 32'h0000_0040, 1, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("holdrst_out_valid", 32'(b32.out_valid), 32'd0);
        chk("holdrst_in_ready", 32'(b32.in_ready), 32'd1);
        b32.out_ready = 1'b1;
        step();

        // N=8: frame {7, 0}.
        send(1, 7, 0);
        send(1, 0, 1);
        @(negedge clk);
        chk("n8_valid", 32'(b8.out_valid), 32'd1);
        chk("n8_bitmap", 32'(b8.out_bitmap), 32'h81);
        chk("n8_count", 32'(b8.out_count), 32'd2);
        chk("n8_dup", 32'(b8.out_dup), 32'd0);
        step();

        // N=8 random valid/ready throttling against the model.
        for (int i = 0; i < 600; i++) begin
            b8.in_valid  = 1'($urandom_range(0, 1));
            b8.in_index  = 3'($urandom);
            b8.in_last   = ($urandom_range(0, 3) == 0);
            b8.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bitmap_assembler.md
BITMAP_ASSEMBLER -- requirements
Module: bitmap_assembler

Interface
REQ-001 Parameter: N, 32, bitmap width; the legal values are the powers of two from 2 to 32.
REQ-002 Derived localparam: IW = clog2(N), the index width; CW = IW+1, the count width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  in_index/in_last are presented.
REQ-006 in_ready  output  1  block accepts an index this cycle.
REQ-007 in_index  input  IW  bit position to set in the current frame.
REQ-008 in_last  input  1  this index closes the frame.
REQ-009 out_valid  output  1  a completed frame is presented.
REQ-010 out_ready  input  1  downstream accepts the frame.
REQ-011 out_bitmap  output  N  the OR of one-hot(in_index) over the frame.
REQ-012 out_count  output  CW  the number of distinct bits set in out_bitmap.
REQ-013 out_dup  output  1  at least one index in the frame was already set.

Function
REQ-014 The block SHALL have an FSM with two states: ACCUM and HOLD.
REQ-015 in_ready SHALL equal (state==ACCUM) and be registered-state driven, with no combinational path from out_ready.
REQ-016 An index is accepted when in_valid && in_ready; an index is never accepted in HOLD.
REQ-017 On accept, acc_bitmap[in_index] SHALL be set to 1 on the next edge; all other bits hold.
REQ-018 On accept, if acc_bitmap[in_index] was 0, acc_count SHALL increment by 1; otherwise acc_count holds and acc_dup SHALL be set (sticky for the frame).
REQ-019 Duplicate detection SHALL use the pre-edge accumulator value; out_count SHALL never exceed N.
REQ-020 Accept with in_last=1 in ACCUM -> HOLD on the next edge; out_valid SHALL be 1 in the first HOLD cycle, giving 1-cycle latency from the last accept.
REQ-021 In HOLD, out_bitmap, out_count and out_dup SHALL be stable until handshake; in_valid and in_index changes SHALL have no effect.
REQ-022 HOLD with out_ready=1 -> ACCUM on the next edge, with acc_bitmap, acc_count and acc_dup cleared to 0 on that same edge.
REQ-023 out_ready asserted in ACCUM SHALL be ignored.
REQ-024 out_bitmap, out_count and out_dup SHALL be driven directly from the accumulator registers; their values are only meaningful while out_valid=1.
REQ-025 Every frame contains at least one index, because in_last travels with an index; no empty-frame path exists.
REQ-026 Throughput: one index per cycle in ACCUM; each frame costs at least 1 HOLD cycle, during which in_ready=0.
REQ-027 A single-index frame (in_last on the first accept) SHALL yield a one-hot bitmap, count=1 and dup=0.

Reset
REQ-028 While rst=1 on an edge: state<=ACCUM; acc_bitmap, acc_count and acc_dup <= 0.
REQ-029 out_valid SHALL be 0 and in_ready SHALL be 0 in any cycle where rst=1; in_ready SHALL be 1 in the first cycle after rst falls.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending frame with no output handshake.
REQ-031 rst SHALL take priority over any simultaneous accept or output handshake.

Verification
REQ-032 N=32; indices 31, 0, 5 (last on 5), out_ready=1 -> out_bitmap=0x80000021, out_count=3, out_dup=0, out_valid one cycle after the last accept.
REQ-033 N=32; indices 7, 7, 7 (last on third) -> out_bitmap=0x00000080, out_count=1, out_dup=1.
REQ-034 N=32; out_ready=0 held for 5 cycles after frame {3} -> out_valid=1 and bitmap=0x8 stable for all 5 cycles, in_ready=0 and in_valid ignored; releasing out_ready -> next frame starts from an empty accumulator.
REQ-035 N=32; 32 distinct indices 0..31 with back-to-back in_valid -> 32 consecutive accepts, out_bitmap=0xFFFFFFFF, out_count=32, out_dup=0.
REQ-036 N=32; rst pulsed after indices 1 and 2 (no last), then frame {4} -> out_bitmap=0x10, out_count=1, out_dup=0.
REQ-037 N=8 build; frame {7, 0} -> out_bitmap=0x81, out_count=2; compare against a scoreboard model under random valid/ready throttling.
